sample_fifo: RTL and testbench
==============================

# sample_fifo

Synchronous first-word-fall-through sample buffer: the storage element on the far side of the FIFO reader and writer stages. Upstream pushes 32-bit sample blocks through a passive req/ack port. The block offers them downstream on an active req/ack port and exports the empty/full status that the reader and writer stages consume. It decouples the producer side (ser2par → fifo_writer) from the consumer side (fifo_reader → par2ser) without requiring the bus.

## Interface
- DWIDTH, 32, sample-block width in bits; vectors ordered [0:DWIDTH-1], bit 0 = MSB
- DEPTH_LOG, 4, log2 of storage depth (DEPTH = 2**DEPTH_LOG = 16 entries)
- AFULL_LEVEL, 12, occupancy at or above which almost_full asserts; legal range 1..DEPTH

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- in_req  in  1  producer has a word on in_data
- in_ack  out  1  word accepted at this clock edge
- in_data  in  DWIDTH  write data
- out_req  out  1  out_data holds a valid head word
- out_ack  in  1  consumer takes the head word at this edge
- out_data  out  DWIDTH  head word
- empty  out  1  occupancy == 0
- full  out  1  occupancy == DEPTH
- almost_full  out  1  occupancy >= AFULL_LEVEL
- level  out  DEPTH_LOG+1  current occupancy, 0..DEPTH
- proto_err  out  1  sticky flag: out_ack seen while out_req low

## Operation
- Push fires at a rising edge when in_req && in_ack.
  - in_ack = in_req && !full && !rst (combinational).
  - The producer holds in_data stable while in_req is high and in_ack is low.
- Pop fires at a rising edge when out_req && out_ack.
  - out_req = !empty.
  - out_data = mem[rd_ptr] while !empty, all zeros while empty.
- wr_ptr and rd_ptr are DEPTH_LOG+1 bits wide. The extra MSB is the wrap bit.
  - empty: pointers are equal.
  - full: low bits are equal and wrap bits differ.
  - Both pointers wrap modulo 2*DEPTH with no special case.
- level = wr_ptr - rd_ptr, taken modulo 2**(DEPTH_LOG+1).
  - Push only: level +1.
  - Pop only: level -1.
  - Push and pop together: level unchanged, both pointers advance.
- Full: in_ack is held low and no write occurs. A pop in that cycle frees one slot, but the slot becomes usable only from the next edge; there is no same-cycle bypass.
- Empty: out_req is low. A push in that cycle makes the word visible on out_req/out_data after that edge; there is no combinational bypass.
- out_ack while out_req is low: ignored, pointers unchanged, proto_err set. proto_err clears only on rst.
- Flag and level registers: empty, full, almost_full and level are registered and updated on the same edge as the pointers. The flags are never derived from the next-state value.

## Timing
- Reset (async assert, release on a clock edge):
  - wr_ptr = rd_ptr = 0
  - empty = 1, full = 0, almost_full = 0, level = 0, proto_err = 0
  - out_req = 0, in_ack = 0, out_data = 0
  - Storage contents are not reset.
- Reset mid-operation: all stored words are discarded. Outputs reach reset values asynchronously.
- Write-to-read latency: 1 cycle. A word pushed at edge t appears on out_data after edge t when the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- Ordering: strict FIFO order, no reordering or duplication.

## Structure
- Shared header stream_defs.vh holds:
  - the DWIDTH / FILTER_DWIDTH defaults
  - the handshake-fire definition (req && ack)
  - the pointer-width derivation from DEPTH_LOG
- One sub-module, sample_fifo_mem: DEPTH x DWIDTH register file.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.
- The top level holds the pointers, flags, level counter and the handshake logic.

## Test plan
- Reset, then push 0x00010002 and 0x00030004 with out_ack low.
  - Expect: level=2, empty=0, out_data=0x00010002 one cycle after the first push.
  - Then pulse out_ack twice. Expect: words popped in order, empty=1, out_data=0.
- Push 16 words 0..15 with in_req held and out_ack low.
  - Expect: almost_full rises on the edge where level reaches 12.
  - Expect: full=1 at level 16, then in_ack=0 with in_req still high.
  - Expect: the 17th word is not written.
- With the FIFO full, assert in_req and out_ack together for one cycle.
  - Expect: the pop occurs, the push is refused, level=15.
  - On the next cycle the push is accepted and level=16.
- Stream 40 words, value = index, with in_req and out_ack both high every cycle after the first word.
  - Expect: level stays at 1.
  - Expect: output sequence 0..39 at one word per cycle, with the pointers wrapping twice.
- Pulse out_ack while empty.
  - Expect: proto_err=1 sticky, level stays 0.
  - Assert rst mid-stream with level=5. Expect: level=0, empty=1, proto_err=0 immediately, before any clock edge.

Source files
------------

// File: rtl/sample_fifo_pkg.sv
// Shared definitions for the sample FIFO: width defaults, the handshake
// fire condition and the pointer-width derivation.
package sample_fifo_pkg;

  localparam int DWIDTH_DEFAULT        = 32;
  localparam int FILTER_DWIDTH_DEFAULT = 16;

  function automatic logic fire(input logic req, input logic ack);
    return req && ack;
  endfunction

  // One extra wrap bit so that full and empty can be told apart.
  function automatic int ptr_width(input int depth_log);
    return depth_log + 1;
  endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// DEPTH x DWIDTH register file: one synchronous write port and one
// asynchronous read port. The contents are not reset.
module sample_fifo_mem #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  logic [0:DWIDTH-1]    wdata,
  input  logic [DEPTH_LOG-1:0] raddr,
  output logic [0:DWIDTH-1]    rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG;

  logic [0:DWIDTH-1] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer with a passive write port, an active
// read port and registered empty/full/almost_full/level status.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DWIDTH      = DWIDTH_DEFAULT,
  parameter int DEPTH_LOG   = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_req,
  output logic                 in_ack,
  input  logic [0:DWIDTH-1]    in_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [0:DWIDTH-1]    out_data,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [DEPTH_LOG:0]   level,
  output logic                 proto_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int PW    = ptr_width(DEPTH_LOG);

  localparam logic [PW-1:0] ONE          = PW'(1);
  localparam logic [PW-1:0] LAST_FREE    = PW'(DEPTH - 1);
  localparam logic [PW-1:0] AFULL_ON_PUSH = PW'(AFULL_LEVEL - 1);
  localparam logic [PW-1:0] AFULL_ON_POP  = PW'(AFULL_LEVEL + 1);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     level_q;
  logic              empty_q;
  logic              full_q;
  logic              afull_q;
  logic              proto_err_q;
  logic              push;
  logic              pop;
  logic [0:DWIDTH-1] rdata;

  assign in_ack  = in_req && !full_q && !rst;
  assign out_req = !empty_q;
  assign push    = fire(in_req, in_ack);
  assign pop     = fire(out_req, out_ack);

  sample_fifo_mem #(
    .DWIDTH    (DWIDTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[DEPTH_LOG-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[DEPTH_LOG-1:0]),
    .rdata (rdata)
  );

  // Flags follow the current occupancy and the direction of change, so they
  // update on the same edge as the pointers without a next-state compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (out_ack && !out_req) begin
        proto_err_q <= 1'b1;
      end
      case ({push, pop})
        2'b10: begin
          level_q <= level_q + ONE;
          empty_q <= 1'b0;
          full_q  <= (level_q == LAST_FREE);
          afull_q <= (level_q >= AFULL_ON_PUSH);
        end
        2'b01: begin
          level_q <= level_q - ONE;
          empty_q <= (level_q == ONE);
          full_q  <= 1'b0;
          afull_q <= (level_q >= AFULL_ON_POP);
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data    = empty_q ? '0 : rdata;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign level       = level_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: a short vector table for basic push/pop,
// then hand-written sequences for fill, full-with-pop, streaming and reset.
module tb_sample_fifo;

  logic        clk;
  logic        rst;
  logic        in_req;
  logic        in_ack;
  logic [0:31] in_data;
  logic        out_req;
  logic        out_ack;
  logic [0:31] out_data;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic [4:0]  level;
  logic        proto_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        in_req;
    logic [31:0] in_data;
    logic        out_ack;
    logic        exp_in_ack;
    logic [4:0]  exp_level;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_afull;
    logic [31:0] exp_out_data;
  } vec_t;

  vec_t vecs [4];

  sample_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .in_req      (in_req),
    .in_ack      (in_ack),
    .in_data     (in_data),
    .out_req     (out_req),
    .out_ack     (out_ack),
    .out_data    (out_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic [31:0] data, input logic ack);
    in_req  = req;
    in_data = data;
    out_ack = ack;
  endtask

  // Inputs are driven 1 time unit after an edge; outputs are sampled 1 unit
  // after the drive (pre-edge) and 1 unit after the next edge (post-edge).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0001_0002, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0001_0002};
    vecs[1] = '{1'b1, 32'h0003_0004, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0001_0002};
    vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0003_0004};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};

    rst = 1'b1;
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    #12;
    check_output("reset_level", 32'(level), 32'd0);
    check_output("reset_empty", 32'(empty), 32'd1);
    check_output("reset_full", 32'(full), 32'd0);
    check_output("reset_afull", 32'(almost_full), 32'd0);
    check_output("reset_proto_err", 32'(proto_err), 32'd0);
    check_output("reset_out_req", 32'(out_req), 32'd0);
    check_output("reset_in_ack", 32'(in_ack), 32'd0);
    check_output("reset_out_data", 32'(out_data), 32'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Basic two-word push and ordered pop.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].in_req, vecs[i].in_data, vecs[i].out_ack);
      #1;
      check_output($sformatf("vec%0d_in_ack", i), 32'(in_ack), 32'(vecs[i].exp_in_ack));
      tick();
      check_output($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check_output($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check_output($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check_output($sformatf("vec%0d_afull", i), 32'(almost_full), 32'(vecs[i].exp_afull));
      check_output($sformatf("vec%0d_out_data", i), 32'(out_data), vecs[i].exp_out_data);
    end

    // Fill with 0..15.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 32'(i), 1'b0);
      #1;
      check_output($sformatf("fill%0d_in_ack", i), 32'(in_ack), 32'd1);
      tick();
      check_output($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
      check_output($sformatf("fill%0d_afull", i), 32'(almost_full), 32'((i + 1) >= 12));
      check_output($sformatf("fill%0d_full", i), 32'(full), 32'((i + 1) == 16));
      check_output($sformatf("fill%0d_head", i), 32'(out_data), 32'd0);
    end

    // 17th word is refused.
    apply_stimulus(1'b1, 32'd99, 1'b0);
    #1;
    check_output("over_in_ack", 32'(in_ack), 32'd0);
    tick();
    check_output("over_level", 32'(level), 32'd16);
    check_output("over_full", 32'(full), 32'd1);

    // Full with simultaneous push and pop: only the pop fires.
    apply_stimulus(1'b1, 32'd100, 1'b1);
    #1;
    check_output("fullpp_in_ack", 32'(in_ack), 32'd0);
    check_output("fullpp_head", 32'(out_data), 32'd0);
    tick();
    check_output("fullpp_level", 32'(level), 32'd15);
    check_output("fullpp_full", 32'(full), 32'd0);
    check_output("fullpp_afull", 32'(almost_full), 32'd1);
    check_output("fullpp_new_head", 32'(out_data), 32'd1);
    apply_stimulus(1'b1, 32'd100, 1'b0);
    #1;
    check_output("refill_in_ack", 32'(in_ack), 32'd1);
    tick();
    check_output("refill_level", 32'(level), 32'd16);
    check_output("refill_full", 32'(full), 32'd1);

    // Drain: 1..15 then 100; the refused 99 must not appear.
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(1'b0, 32'd0, 1'b1);
      #1;
      check_output($sformatf("drain%0d_data", k), 32'(out_data), (k < 15) ? 32'(k + 1) : 32'd100);
      tick();
      check_output($sformatf("drain%0d_level", k), 32'(level), 32'(15 - k));
    end
    check_output("drain_empty", 32'(empty), 32'd1);
    check_output("drain_afull", 32'(almost_full), 32'd0);

    // Streaming 40 words with push and pop every cycle after the first.
    apply_stimulus(1'b1, 32'd0, 1'b0);
    tick();
    for (int i = 1; i < 40; i++) begin
      apply_stimulus(1'b1, 32'(i), 1'b1);
      #1;
      check_output($sformatf("stream%0d_data", i), 32'(out_data), 32'(i - 1));
      tick();
      check_output($sformatf("stream%0d_level", i), 32'(level), 32'd1);
    end
    apply_stimulus(1'b0, 32'd0, 1'b1);
    #1;
    check_output("stream_last_data", 32'(out_data), 32'd39);
    tick();
    check_output("stream_end_empty", 32'(empty), 32'd1);
    check_output("stream_end_level", 32'(level), 32'd0);

    // out_ack while empty sets a sticky protocol error.
    apply_stimulus(1'b0, 32'd0, 1'b1);
    tick();
    check_output("perr_set", 32'(proto_err), 32'd1);
    check_output("perr_level", 32'(level), 32'd0);
    check_output("perr_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 32'(200 + i), 1'b0);
      tick();
    end
    check_output("perr_sticky", 32'(proto_err), 32'd1);
    check_output("pre_rst_level", 32'(level), 32'd5);
    check_output("pre_rst_head", 32'(out_data), 32'd200);

    // Asynchronous reset mid-stream, observed before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_level", 32'(level), 32'd0);
    check_output("arst_empty", 32'(empty), 32'd1);
    check_output("arst_proto_err", 32'(proto_err), 32'd0);
    check_output("arst_out_req", 32'(out_req), 32'd0);
    check_output("arst_in_ack", 32'(in_ack), 32'd0);
    check_output("arst_out_data", 32'(out_data), 32'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_output("post_rst_level", 32'(level), 32'd0);
    check_output("post_rst_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
